// File: rtl/cube_root_seq.sv
// rtl/cube_root_seq.sv - sequential restoring integer cube root, one root bit per cycle
// Unsigned or two's-complement operand; result truncated toward zero, remainder carries sign of x.
module cube_root_seq #(
  parameter int WIDTH  = 12,
  parameter int SIGNED = 0,
  localparam int RW    = (WIDTH + 2) / 3,
  localparam int RTW   = RW + SIGNED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [RTW-1:0]   root,
  output logic [WIDTH-1:0] rem
);
  // BW covers the largest step factor (< 2^(3*RW+1)) so nothing is ever truncated
  localparam int BW = 3 * RW + 3;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] residue, residue_n, mag;
  logic [RW-1:0]    y, y_n;
  logic [RTW-1:0]   root_mag;
  logic [CW-1:0]    cnt;
  logic             neg, x_neg, ge;
  logic [BW-1:0]    y2, b, shamt;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == CALC);
    done  = (state == DONE);
  end

  // one restoring step: try appending a 1 bit to the partial root
  always_comb begin
    x_neg     = (SIGNED != 0) && x[WIDTH-1];
    mag       = x_neg ? -x : x;
    y2        = BW'(y) << 1;
    shamt     = BW'(cnt) * BW'(3);
    b         = (BW'(3) * y2 * (y2 + BW'(1)) + BW'(1)) << shamt;
    ge        = BW'(residue) >= b;
    residue_n = ge ? WIDTH'(BW'(residue) - b) : residue;
    y_n       = ge ? RW'(y2 + BW'(1)) : RW'(y2);
    root_mag  = RTW'(y_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      residue <= '0;
      y       <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      root    <= '0;
      rem     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          residue <= mag;
          neg     <= x_neg;
          y       <= '0;
          cnt     <= CW'(RW - 1);
        end
        CALC: begin
          residue <= residue_n;
          y       <= y_n;
          if (cnt == '0) begin
            root <= neg ? -root_mag : root_mag;
            rem  <= neg ? -residue_n : residue_n;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cube_root_seq.sv
// tb/tb_cube_root_seq.sv - scoreboard bench for cube_root_seq over four parameter sets
// Ids: 0 = 12-bit unsigned, 1 = 12-bit signed, 2 = 9-bit unsigned, 3 = 9-bit signed.
module tb_cube_root_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_s, start_u, start_t;
  logic [11:0] x_a, x_s;
  logic [8:0]  x_u, x_t;
  logic        ready_a, busy_a, done_a, ready_s, busy_s, done_s;
  logic        ready_u, busy_u, done_u, ready_t, busy_t, done_t;
  logic [3:0]  root_a;
  logic [4:0]  root_s;
  logic [2:0]  root_u;
  logic [3:0]  root_t;
  logic [11:0] rem_a, rem_s;
  logic [8:0]  rem_u, rem_t;

  cube_root_seq #(.WIDTH(12), .SIGNED(0)) dut_a (.clk(clk), .rst(rst), .start(start_a), .x(x_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .root(root_a), .rem(rem_a));
  cube_root_seq #(.WIDTH(12), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .start(start_s), .x(x_s),
    .ready(ready_s), .busy(busy_s), .done(done_s), .root(root_s), .rem(rem_s));
  cube_root_seq #(.WIDTH(9), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .start(start_u), .x(x_u),
    .ready(ready_u), .busy(busy_u), .done(done_u), .root(root_u), .rem(rem_u));
  cube_root_seq #(.WIDTH(9), .SIGNED(1)) dut_t (.clk(clk), .rst(rst), .start(start_t), .x(x_t),
    .ready(ready_t), .busy(busy_t), .done(done_t), .root(root_t), .rem(rem_t));

  typedef struct {
    int          id;
    longint      at;
    logic [31:0] root;
    logic [31:0] rem;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  logic [31:0] last_r, last_m;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wd(input int id);
    return (id < 2) ? 12 : 9;
  endfunction
  function automatic int sg(input int id);
    return id % 2;
  endfunction
  function automatic int rw(input int id);
    return (wd(id) + 2) / 3;
  endfunction
  function automatic logic [31:0] mask(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic get_ready(input int id);
    case (id) 0: return ready_a; 1: return ready_s; 2: return ready_u; default: return ready_t; endcase
  endfunction
  function automatic logic get_busy(input int id);
    case (id) 0: return busy_a; 1: return busy_s; 2: return busy_u; default: return busy_t; endcase
  endfunction
  function automatic logic get_done(input int id);
    case (id) 0: return done_a; 1: return done_s; 2: return done_u; default: return done_t; endcase
  endfunction
  function automatic logic [31:0] get_root(input int id);
    case (id)
      0: return {28'd0, root_a};
      1: return {27'd0, root_s};
      2: return {29'd0, root_u};
      default: return {28'd0, root_t};
    endcase
  endfunction
  function automatic logic [31:0] get_rem(input int id);
    case (id)
      0: return {20'd0, rem_a};
      1: return {20'd0, rem_s};
      2: return {23'd0, rem_u};
      default: return {23'd0, rem_t};
    endcase
  endfunction

  // golden model: plain integer search for the largest r with r^3 <= |x|
  function automatic void model(input int id, input logic [31:0] v,
                                output logic [31:0] r_o, output logic [31:0] m_o);
    longint xv, m, r;
    int     w;
    w  = wd(id);
    xv = longint'(v & mask(w));
    if (sg(id) == 1 && xv >= (longint'(1) << (w - 1))) xv = xv - (longint'(1) << w);
    m = (xv < 0) ? -xv : xv;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= m) r++;
    if (xv < 0) r = -r;
    r_o = 32'(r) & mask(rw(id) + sg(id));
    m_o = 32'(xv - r * r * r) & mask(w);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int id, input logic st, input logic [31:0] v);
    case (id)
      0: begin start_a = st; x_a = v[11:0]; end
      1: begin start_s = st; x_s = v[11:0]; end
      2: begin start_u = st; x_u = v[8:0]; end
      default: begin start_t = st; x_t = v[8:0]; end
    endcase
  endtask

  task automatic push(input int id, input logic [31:0] v, input longint at);
    logic [31:0] r, m;
    model(id, v, r, m);
    last_r = r;
    last_m = m;
    q.push_back('{id, at, r, m});
  endtask

  task automatic wait_ready(input int id);
    int n;
    n = 0;
    while (!get_ready(id) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: id %0d never returned ready, required within 200 cycles", id);
    end
  endtask

  task automatic run_op(input int id, input logic [31:0] v, input bit poke);
    wait_ready(id);
    drive(id, 1'b1, v);
    push(id, v, cyc + 1 + rw(id));
    @(negedge clk);
    drive(id, 1'b0, $urandom);
    if (poke) begin
      @(negedge clk);
      drive(id, 1'b1, $urandom);
      @(negedge clk);
      drive(id, 1'b0, $urandom);
    end
    wait_ready(id);
    if (poke) begin
      @(negedge clk);
      check("hold_root", get_root(id), last_r);
      check("hold_rem", get_rem(id), last_m);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (get_done(i)) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: id %0d raised done, required no pending result", i);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_id", 64'(i), 64'(e.id));
          check("latency", 64'(cyc), 64'(e.at));
          check("root", get_root(i), e.root);
          check("rem", get_rem(i), e.rem);
          check("exclusive", {get_ready(i), get_busy(i)}, 2'b00);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint c;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", get_ready(i), 1'b1);
      check("rst_busy", get_busy(i), 1'b0);
      check("rst_done", get_done(i), 1'b0);
      check("rst_root", get_root(i), 32'd0);
      check("rst_rem", get_rem(i), 32'd0);
    end

    // first edge out of reset with start high is an accept edge
    drive(0, 1'b1, 32'd4095);
    push(0, 32'd4095, cyc + 1 + 4);
    rst = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 32'd0);
    wait_ready(0);

    run_op(0, 32'd1000, 1'b1);
    run_op(0, 32'd0, 1'b0);
    run_op(0, 32'd7, 1'b0);
    run_op(1, 32'h800, 1'b1);
    run_op(1, 32'hFE5, 1'b0);

    // start held high across two operations
    wait_ready(0);
    c = cyc;
    drive(0, 1'b1, 32'd64);
    push(0, 32'd64, c + 5);
    push(0, 32'd125, c + 11);
    @(negedge clk);
    drive(0, 1'b1, 32'd125);
    repeat (6) @(negedge clk);
    check("held_accept", get_busy(0), 1'b1);
    drive(0, 1'b0, 32'd0);
    wait_ready(0);

    // abort after two iterations; no done may follow
    drive(0, 1'b1, 32'd100);
    @(negedge clk);
    drive(0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", ready_a, 1'b1);
    check("abort_busy", busy_a, 1'b0);
    check("abort_root", {28'd0, root_a}, 32'd0);
    check("abort_rem", {20'd0, rem_a}, 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    run_op(0, 32'd8, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(0, $urandom, (i % 10) == 0);
      run_op(1, $urandom, (i % 10) == 5);
    end
    for (int v = 0; v < 512; v++) begin
      run_op(2, 32'(v), 1'b0);
      run_op(3, 32'(v), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
